// File: rtl/audio_serial_tx.sv
// audio_serial_tx: I2S/LJ/RJ TDM serial audio transmitter with frame FIFO; AUDIO_TX_MUTE_ON_UNDERRUN_EN silences underrun frames
module audio_serial_tx #(
  parameter int AUDIO_DW   = 16,
  parameter int SLOT_W     = 32,
  parameter int CHANNELS   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ce,
  input  logic [1:0]                       mode,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [CHANNELS*AUDIO_DW-1:0]     s_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             underrun,
  output logic                             sclk,
  output logic                             lrclk,
  output logic                             sdata
);
  localparam int BW  = $clog2(SLOT_W);
  localparam int CW  = $clog2(CHANNELS);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH+1);
  localparam int DIW = $clog2(AUDIO_DW);
  localparam int FW  = CHANNELS*AUDIO_DW;
  logic          sclk_q, sclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d, underrun_q, underrun_d;
  logic [BW-1:0] b_q, b_d, off, rel;
  logic [CW-1:0] c_q, c_d;
  logic [1:0]    mode_q, mode_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AUDIO_DW-1:0] sample;
  logic          fe, fs, push, pop, last_b;
  assign s_ready    = level_q != LW'(FIFO_DEPTH);
  assign fifo_level = level_q;
  assign underrun   = underrun_q;
  assign sclk       = sclk_q;
  assign lrclk      = lrclk_q;
  assign sdata      = sdata_q;
  // next-state: position advances on sclk falling edges, frame start pops the FIFO, serial bit is placed by format
  always_comb begin
    fe         = ce && sclk_q;
    last_b     = b_q == BW'(SLOT_W-1);
    fs         = fe && last_b && c_q == CW'(CHANNELS-1);
    push       = s_valid && s_ready;
    pop        = fs && level_q != '0;
    sclk_d     = ce ? !sclk_q : sclk_q;
    b_d        = !fe ? b_q : last_b ? '0 : b_q + BW'(1);
    c_d        = !(fe && last_b) ? c_q : c_q == CW'(CHANNELS-1) ? '0 : c_q + CW'(1);
    mode_d     = fs ? mode : mode_q;
`ifdef AUDIO_TX_MUTE_ON_UNDERRUN_EN
    frame_d    = !fs ? frame_q : pop ? mem_q[rd_q] : '0;
`else
    frame_d    = !fs ? frame_q : pop ? mem_q[rd_q] : frame_q;
`endif
    underrun_d = fs && level_q == '0;
    wr_d       = push ? wr_q + PW'(1) : wr_q;
    rd_d       = pop ? rd_q + PW'(1) : rd_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    sample     = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (c_d == CW'(i)) sample = frame_d[i*AUDIO_DW +: AUDIO_DW];
    off        = mode_d == 2'b01 ? '0 : mode_d == 2'b10 ? BW'(SLOT_W-AUDIO_DW) : BW'(1);
    rel        = b_d - off;
    sdata_d    = fe ? (b_d >= off && rel < BW'(AUDIO_DW) && sample[DIW'(AUDIO_DW-1) - rel[DIW-1:0]]) : sdata_q;
    lrclk_d    = fe ? c_d >= CW'(CHANNELS/2) : lrclk_q;
  end
  // state registers; reset parks the position at the last bit so the first falling edge starts a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_q     <= 1'b1;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      b_q        <= BW'(SLOT_W-1);
      c_q        <= CW'(CHANNELS-1);
      mode_q     <= '0;
      frame_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
    end else begin
      sclk_q     <= sclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      b_q        <= b_d;
      c_q        <= c_d;
      mode_q     <= mode_d;
      frame_q    <= frame_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
    end
  end
  // frame FIFO storage
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_q] <= s_data;
  end
endmodule

// File: tb/tb_audio_serial_tx.sv
// tb_audio_serial_tx: directed checks of the serial audio transmitter in 2-channel and 4-channel TDM builds
module tb_audio_serial_tx;
  logic        clk = 0, rst = 1, ce = 0;
  logic [1:0]  mode = 2'b00;
  logic        a_valid = 0, a_ready, a_underrun, a_sclk, a_lrclk, a_sdata;
  logic [31:0] a_data = '0;
  logic [2:0]  a_level;
  logic        b_valid = 0, b_ready, b_underrun, b_sclk, b_lrclk, b_sdata;
  logic [63:0] b_data = '0;
  logic [2:0]  b_level;
  int checks = 0, errors = 0;

  audio_serial_tx u_a (
    .clk(clk), .reset(rst), .ce(ce), .mode(mode), .s_valid(a_valid), .s_ready(a_ready),
    .s_data(a_data), .fifo_level(a_level), .underrun(a_underrun), .sclk(a_sclk),
    .lrclk(a_lrclk), .sdata(a_sdata)
  );

  audio_serial_tx #(.AUDIO_DW(16), .SLOT_W(24), .CHANNELS(4), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .reset(rst), .ce(ce), .mode(2'b00), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .fifo_level(b_level), .underrun(b_underrun), .sclk(b_sclk),
    .lrclk(b_lrclk), .sdata(b_sdata)
  );

  always #5 clk = ~clk;

  // receiver model: frame begins at lrclk fall, bits taken at each sclk fall, first bit lands in the MSB
  logic [63:0] a_bits_q[$], a_lr_q[$];
  int          a_ur_q[$];
  logic [63:0] a_sh, a_lsh;
  int          a_idx = -1, a_ur = 0;
  logic        a_ps = 1, a_pl = 1;
  always @(negedge clk) begin
    if (rst) a_idx = -1;
    else if (a_ps && !a_sclk) begin
      if (a_pl && !a_lrclk) begin a_idx = 0; a_ur = 0; end
      else if (a_idx >= 0) a_idx++;
      if (a_idx >= 0) begin a_sh = {a_sh[62:0], a_sdata}; a_lsh = {a_lsh[62:0], a_lrclk}; end
    end
    if (!rst && a_underrun) a_ur++;
    if (!rst && a_ps && !a_sclk && a_idx == 63) begin
      a_bits_q.push_back(a_sh); a_lr_q.push_back(a_lsh); a_ur_q.push_back(a_ur); a_idx = -1;
    end
    a_ps = a_sclk; a_pl = a_lrclk;
  end

  logic [95:0] b_bits_q[$], b_lr_q[$];
  int          b_ur_q[$];
  logic [95:0] b_sh, b_lsh;
  int          b_idx = -1, b_ur = 0;
  logic        b_ps = 1, b_pl = 1;
  always @(negedge clk) begin
    if (rst) b_idx = -1;
    else if (b_ps && !b_sclk) begin
      if (b_pl && !b_lrclk) begin b_idx = 0; b_ur = 0; end
      else if (b_idx >= 0) b_idx++;
      if (b_idx >= 0) begin b_sh = {b_sh[94:0], b_sdata}; b_lsh = {b_lsh[94:0], b_lrclk}; end
    end
    if (!rst && b_underrun) b_ur++;
    if (!rst && b_ps && !b_sclk && b_idx == 95) begin
      b_bits_q.push_back(b_sh); b_lr_q.push_back(b_lsh); b_ur_q.push_back(b_ur); b_idx = -1;
    end
    b_ps = b_sclk; b_pl = b_lrclk;
  end

  task automatic wait_a(input int n);
    for (int i = 0; i < 3000 && a_bits_q.size() < n; i++) @(negedge clk);
    checks++;
    if (a_bits_q.size() < n) begin
      errors++;
      $display("FAIL wait_a frames got %0d exp %0d", a_bits_q.size(), n);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "frame wait expired");
    end
  endtask

  task automatic push_a(input logic [31:0] d);
    @(negedge clk); a_valid = 1; a_data = d;
    for (int i = 0; i < 400 && !a_ready; i++) @(negedge clk);
    checks++;
    if (!a_ready) begin errors++; $display("FAIL push_a s_ready got 0 exp 1"); end
    @(negedge clk); a_valid = 0;
  endtask

  task automatic do_reset;
    @(negedge clk); rst = 1; ce = 0; a_valid = 0; b_valid = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks += 7;
    if (a_sclk !== 1'b1)     begin errors++; $display("FAIL reset_sclk got %b exp 1", a_sclk); end
    if (a_lrclk !== 1'b1)    begin errors++; $display("FAIL reset_lrclk got %b exp 1", a_lrclk); end
    if (a_sdata !== 1'b0)    begin errors++; $display("FAIL reset_sdata got %b exp 0", a_sdata); end
    if (a_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b exp 0", a_underrun); end
    if (a_level !== 3'd0)    begin errors++; $display("FAIL reset_level got %0d exp 0", a_level); end
    if (a_ready !== 1'b1)    begin errors++; $display("FAIL reset_ready got %b exp 1", a_ready); end
    if (b_lrclk !== 1'b1)    begin errors++; $display("FAIL reset_b_lrclk got %b exp 1", b_lrclk); end
    rst = 0;
  endtask

  task automatic test_modes;
    logic [63:0] exp_bits [3];
    exp_bits = '{64'h40008000_3FFF0000, 64'h80010000_7FFE0000, 64'h00008001_00007FFE};
    mode = 2'b00;
    @(negedge clk); a_valid = 1; a_data = 32'h7FFE_8001; b_valid = 1; b_data = 64'h0004_0003_0002_0001;
    @(negedge clk); a_valid = 0; b_valid = 0;
    checks++;
    if (a_level !== 3'd1) begin errors++; $display("FAIL modes_level got %0d exp 1", a_level); end
    ce = 1;
    @(negedge clk); mode = 2'b01;
    push_a(32'h7FFE_8001);
    wait_a(1);
    repeat (10) @(negedge clk);
    mode = 2'b10;
    push_a(32'h7FFE_8001);
    wait_a(2);
    repeat (10) @(negedge clk);
    mode = 2'b00;
    wait_a(3);
    for (int k = 0; k < 3; k++) begin
      checks += 2;
      if (a_bits_q[k] !== exp_bits[k]) begin errors++; $display("FAIL modes_bits%0d got %h exp %h", k, a_bits_q[k], exp_bits[k]); end
      if (a_ur_q[k] !== 0) begin errors++; $display("FAIL modes_underrun%0d got %0d exp 0", k, a_ur_q[k]); end
    end
    checks++;
    if (a_lr_q[0] !== 64'h00000000_FFFFFFFF) begin errors++; $display("FAIL modes_lrclk got %h exp 00000000ffffffff", a_lr_q[0]); end
  endtask

  task automatic test_tdm;
    for (int i = 0; i < 1000 && b_bits_q.size() < 1; i++) @(negedge clk);
    checks++;
    if (b_bits_q.size() < 1) begin
      errors++; $display("FAIL tdm_frames got 0 exp 1");
    end else begin
      checks += 3;
      if (b_bits_q[0] !== 96'h000080_000100_000180_000200) begin errors++; $display("FAIL tdm_bits got %h exp 000080000100000180000200", b_bits_q[0]); end
      if (b_lr_q[0] !== 96'h000000000000_FFFFFFFFFFFF) begin errors++; $display("FAIL tdm_lrclk got %h exp 000000000000ffffffffffff", b_lr_q[0]); end
      if (b_ur_q[0] !== 0) begin errors++; $display("FAIL tdm_underrun got %0d exp 0", b_ur_q[0]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] fr [5];
    logic [63:0] exp_bits [5];
    int n0;
    fr = '{32'hEEEE_1111, 32'hDDDD_2222, 32'hCCCC_3333, 32'hBBBB_4444, 32'hAAAA_5555};
    exp_bits = '{64'h11110000_EEEE0000, 64'h22220000_DDDD0000, 64'h33330000_CCCC0000,
                 64'h44440000_BBBB0000, 64'h55550000_AAAA0000};
    do_reset;
    mode = 2'b01;
    n0 = a_bits_q.size();
    for (int i = 0; i < 4; i++) push_a(fr[i]);
    a_valid = 1; a_data = fr[4];
    checks += 2;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b exp 0", a_ready); end
    if (a_level !== 3'd4) begin errors++; $display("FAIL b2b_full_level got %0d exp 4", a_level); end
    ce = 1;
    @(negedge clk);
    checks += 2;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_pop_ready got %b exp 1", a_ready); end
    if (a_level !== 3'd3) begin errors++; $display("FAIL b2b_pop_level got %0d exp 3", a_level); end
    @(negedge clk);
    checks += 2;
    if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_refill_ready got %b exp 0", a_ready); end
    if (a_level !== 3'd4) begin errors++; $display("FAIL b2b_refill_level got %0d exp 4", a_level); end
    a_valid = 0;
    wait_a(n0 + 5);
    for (int k = 0; k < 5; k++) begin
      checks += 2;
      if (a_bits_q[n0+k] !== exp_bits[k]) begin errors++; $display("FAIL b2b_bits%0d got %h exp %h", k, a_bits_q[n0+k], exp_bits[k]); end
      if (a_ur_q[n0+k] !== 0) begin errors++; $display("FAIL b2b_underrun%0d got %0d exp 0", k, a_ur_q[n0+k]); end
    end
  endtask

  task automatic test_drain;
    logic [63:0] rep;
    int n0;
`ifdef AUDIO_TX_MUTE_ON_UNDERRUN_EN
    rep = 64'h0;
`else
    rep = 64'h12340000_56780000;
`endif
    do_reset;
    mode = 2'b01;
    n0 = a_bits_q.size();
    push_a(32'h5678_1234);
    ce = 1;
    wait_a(n0 + 3);
    checks += 6;
    if (a_bits_q[n0] !== 64'h12340000_56780000) begin errors++; $display("FAIL drain_first_bits got %h exp 1234000056780000", a_bits_q[n0]); end
    if (a_ur_q[n0] !== 0) begin errors++; $display("FAIL drain_first_underrun got %0d exp 0", a_ur_q[n0]); end
    if (a_bits_q[n0+1] !== rep) begin errors++; $display("FAIL drain_under1_bits got %h exp %h", a_bits_q[n0+1], rep); end
    if (a_ur_q[n0+1] !== 1) begin errors++; $display("FAIL drain_under1_pulse got %0d exp 1", a_ur_q[n0+1]); end
    if (a_bits_q[n0+2] !== rep) begin errors++; $display("FAIL drain_under2_bits got %h exp %h", a_bits_q[n0+2], rep); end
    if (a_ur_q[n0+2] !== 1) begin errors++; $display("FAIL drain_under2_pulse got %0d exp 1", a_ur_q[n0+2]); end
  endtask

  task automatic test_mid_reset;
    int n0;
    for (int i = 0; i < 400 && a_idx != 1; i++) @(negedge clk);
    push_a(32'hCAFE_BEEF);
    checks++;
    if (a_level !== 3'd1) begin errors++; $display("FAIL midrst_prelevel got %0d exp 1", a_level); end
    for (int i = 0; i < 400 && a_idx != 6; i++) @(negedge clk);
    rst = 1; ce = 0;
    @(negedge clk);
    checks += 5;
    if (a_sclk !== 1'b1)     begin errors++; $display("FAIL midrst_sclk got %b exp 1", a_sclk); end
    if (a_lrclk !== 1'b1)    begin errors++; $display("FAIL midrst_lrclk got %b exp 1", a_lrclk); end
    if (a_sdata !== 1'b0)    begin errors++; $display("FAIL midrst_sdata got %b exp 0", a_sdata); end
    if (a_level !== 3'd0)    begin errors++; $display("FAIL midrst_level got %0d exp 0", a_level); end
    if (a_underrun !== 1'b0) begin errors++; $display("FAIL midrst_underrun got %b exp 0", a_underrun); end
    @(negedge clk); rst = 0;
    n0 = a_bits_q.size();
    push_a(32'hF00F_00FF);
    ce = 1;
    wait_a(n0 + 1);
    checks += 2;
    if (a_bits_q[n0] !== 64'h00FF0000_F00F0000) begin errors++; $display("FAIL midrst_bits got %h exp 00ff0000f00f0000", a_bits_q[n0]); end
    if (a_ur_q[n0] !== 0) begin errors++; $display("FAIL midrst_underrun_after got %0d exp 0", a_ur_q[n0]); end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_tdm;
    test_back_to_back;
    test_drain;
    test_mid_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
